memory_register_bank: RTL and testbench

- Parametrised, multi-entry register bank for the cache memory subsystem.
- DEPTH entries of WIDTH bits, each with a valid bit; supports indexed write, delete (invalidate) and registered read.
- Tracks live occupancy, full/empty status and the lowest free slot so the cache controller can allocate entries without scanning.
- Sits between the controller FSM and key/value storage; one instance per stored field.

---
 rtl/memory_pkg.sv | 23 ++
 rtl/memory_free_slot_finder.sv | 26 ++
 rtl/memory_register_bank.sv | 129 ++++++++++++
 tb/tb_memory_register_bank.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and helpers for the cache memory register banks.
package memory_pkg;

  // Index width for a bank of `depth` entries; never narrower than one bit.
  function automatic int unsigned calc_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Operation the controller issues to a bank in a given cycle.
  typedef enum logic [1:0] {
    BankOpNone   = 2'd0,
    BankOpWrite  = 2'd1,
    BankOpDelete = 2'd2
  } bank_op_e;

  // Width-independent part of a read response. Each bank wraps it together
  // with its own WIDTH-bit data field to form the full response struct.
  typedef struct packed {
    logic valid;
    logic done;
  } rd_status_t;

endpackage

// File: rtl/memory_free_slot_finder.sv
// Lowest-index priority encoder over a valid mask: reports the first free
// (invalid) entry so allocators never need to scan.
module memory_free_slot_finder
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = calc_idx_w(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_mask,
  output logic [IDX_W-1:0] free_idx,
  output logic             free_found
);

  // Scan from the top down so the lowest free index is the last one assigned.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_mask[i]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_register_bank.sv
// Multi-entry register bank with per-entry valid bits, indexed write/delete,
// one-cycle registered read and live occupancy / free-slot tracking.
// Build option: define MEMORY_BANK_BYPASS_EN to forward same-cycle write data
// to a read of the same index (write-first); otherwise reads see pre-write data.
module memory_register_bank
  import memory_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = calc_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             del_en,
  input  logic [IDX_W-1:0] del_idx,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_done,
  output logic [DEPTH-1:0] valid_mask,
  output logic [IDX_W:0]   used_count,
  output logic             full,
  output logic             empty,
  output logic [IDX_W-1:0] free_idx,
  output logic             free_found
);

  localparam int unsigned CntW = IDX_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    rd_status_t       status;
  } rd_rsp_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CntW-1:0]  used_count_q, used_count_d;
  rd_rsp_t          rd_rsp_q, rd_rsp_d;

  logic wr_ok, del_ok, rd_ok;
  logic cnt_inc, cnt_dec;

  // Request qualification: out-of-range indices are dropped, a delete of an
  // invalid entry is a no-op, and a same-index write overrides the delete.
  always_comb begin
    wr_ok   = wr_en && (32'(wr_idx) < DEPTH);
    rd_ok   = rd_en && (32'(rd_idx) < DEPTH);
    del_ok  = del_en && (32'(del_idx) < DEPTH) && valid_q[del_idx]
              && !(wr_ok && (wr_idx == del_idx));
    cnt_inc = wr_ok && !valid_q[wr_idx];
    cnt_dec = del_ok;
  end

  // Next-state for storage, valid bits and the incremental occupancy count.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (del_ok) begin
      valid_d[del_idx] = 1'b0;
    end
    if (wr_ok) begin
      mem_d[wr_idx]   = wr_data;
      valid_d[wr_idx] = 1'b1;
    end
    used_count_d = used_count_q + CntW'(cnt_inc) - CntW'(cnt_dec);
  end

  // Read response: done for any rd_en, data zeroed for invalid/out-of-range
  // entries, data held when no read is issued.
  always_comb begin
    rd_rsp_d              = rd_rsp_q;
    rd_rsp_d.status.done  = rd_en;
    rd_rsp_d.status.valid = 1'b0;
    if (rd_en) begin
      rd_rsp_d.data = '0;
      if (rd_ok && valid_q[rd_idx]) begin
        rd_rsp_d.data         = mem_q[rd_idx];
        rd_rsp_d.status.valid = 1'b1;
      end
`ifdef MEMORY_BANK_BYPASS_EN
      if (rd_ok && wr_ok && (rd_idx == wr_idx)) begin
        rd_rsp_d.data         = wr_data;
        rd_rsp_d.status.valid = 1'b1;
      end
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q        <= '{default: '0};
      valid_q      <= '0;
      used_count_q <= '0;
      rd_rsp_q     <= '0;
    end else begin
      mem_q        <= mem_d;
      valid_q      <= valid_d;
      used_count_q <= used_count_d;
      rd_rsp_q     <= rd_rsp_d;
    end
  end

  memory_free_slot_finder #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_free_slot_finder (
    .valid_mask (valid_q),
    .free_idx   (free_idx),
    .free_found (free_found)
  );

  // Status outputs derive only from registered state.
  always_comb begin
    rd_data    = rd_rsp_q.data;
    rd_valid   = rd_rsp_q.status.valid;
    rd_done    = rd_rsp_q.status.done;
    valid_mask = valid_q;
    used_count = used_count_q;
    full       = (used_count_q == CntW'(DEPTH));
    empty      = (used_count_q == '0);
  end

endmodule

// File: tb/tb_memory_register_bank.sv
// Directed self-checking bench: an 8-entry bank for the main scenarios and a
// 5-entry bank for non-power-of-two bounds handling.
module tb_memory_register_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // 8-entry, 32-bit instance
  logic        a_wr_en = 0, a_del_en = 0, a_rd_en = 0;
  logic [2:0]  a_wr_idx = 0, a_del_idx = 0, a_rd_idx = 0;
  logic [31:0] a_wr_data = 0, a_rd_data;
  logic        a_rd_valid, a_rd_done, a_full, a_empty, a_free_found;
  logic [7:0]  a_valid_mask;
  logic [3:0]  a_used_count;
  logic [2:0]  a_free_idx;

  // 5-entry, 8-bit instance
  logic        b_wr_en = 0, b_del_en = 0, b_rd_en = 0;
  logic [2:0]  b_wr_idx = 0, b_del_idx = 0, b_rd_idx = 0;
  logic [7:0]  b_wr_data = 0, b_rd_data;
  logic        b_rd_valid, b_rd_done, b_full, b_empty, b_free_found;
  logic [4:0]  b_valid_mask;
  logic [3:0]  b_used_count;
  logic [2:0]  b_free_idx;

  memory_register_bank #(
    .WIDTH (32),
    .DEPTH (8)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (a_wr_en),
    .wr_idx     (a_wr_idx),
    .wr_data    (a_wr_data),
    .del_en     (a_del_en),
    .del_idx    (a_del_idx),
    .rd_en      (a_rd_en),
    .rd_idx     (a_rd_idx),
    .rd_data    (a_rd_data),
    .rd_valid   (a_rd_valid),
    .rd_done    (a_rd_done),
    .valid_mask (a_valid_mask),
    .used_count (a_used_count),
    .full       (a_full),
    .empty      (a_empty),
    .free_idx   (a_free_idx),
    .free_found (a_free_found)
  );

  memory_register_bank #(
    .WIDTH (8),
    .DEPTH (5)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (b_wr_en),
    .wr_idx     (b_wr_idx),
    .wr_data    (b_wr_data),
    .del_en     (b_del_en),
    .del_idx    (b_del_idx),
    .rd_en      (b_rd_en),
    .rd_idx     (b_rd_idx),
    .rd_data    (b_rd_data),
    .rd_valid   (b_rd_valid),
    .rd_done    (b_rd_done),
    .valid_mask (b_valid_mask),
    .used_count (b_used_count),
    .full       (b_full),
    .empty      (b_empty),
    .free_idx   (b_free_idx),
    .free_found (b_free_found)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_wr_en = 0; a_del_en = 0; a_rd_en = 0;
  endtask

  initial begin
    logic [31:0] exp_collide;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("por_empty", 32'(a_empty), 32'd1);
    check_eq("por_free_found", 32'(a_free_found), 32'd1);

    // 1. Asynchronous reset mid-cycle drops a pending read result
    a_wr_en = 1; a_wr_idx = 0; a_wr_data = 32'h5A;
    step();
    idle_a(); a_rd_en = 1; a_rd_idx = 0;
    step();
    idle_a();
    check_eq("pre_rst_rd_valid", 32'(a_rd_valid), 32'd1);
    check_eq("pre_rst_count", 32'(a_used_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_empty", 32'(a_empty), 32'd1);
    check_eq("rst_full", 32'(a_full), 32'd0);
    check_eq("rst_count", 32'(a_used_count), 32'd0);
    check_eq("rst_free_idx", 32'(a_free_idx), 32'd0);
    check_eq("rst_rd_valid", 32'(a_rd_valid), 32'd0);
    check_eq("rst_rd_done", 32'(a_rd_done), 32'd0);
    check_eq("rst_rd_data", a_rd_data, 32'd0);
    #1 rst = 1'b0;

    // 2. Fill all eight entries
    for (int i = 0; i < 8; i++) begin
      a_wr_en = 1; a_wr_idx = 3'(i); a_wr_data = 32'hA0 + 32'(i);
      step();
      check_eq($sformatf("fill_count_%0d", i), 32'(a_used_count), 32'(i + 1));
    end
    idle_a();
    check_eq("fill_full", 32'(a_full), 32'd1);
    check_eq("fill_free_found", 32'(a_free_found), 32'd0);
    check_eq("fill_free_idx", 32'(a_free_idx), 32'd0);
    check_eq("fill_mask", 32'(a_valid_mask), 32'hFF);
    a_rd_en = 1; a_rd_idx = 3;
    step();
    idle_a();
    check_eq("rd3_data", a_rd_data, 32'hA3);
    check_eq("rd3_valid", 32'(a_rd_valid), 32'd1);
    check_eq("rd3_done", 32'(a_rd_done), 32'd1);
    step();
    check_eq("rd_idle_done", 32'(a_rd_done), 32'd0);
    check_eq("rd_idle_valid", 32'(a_rd_valid), 32'd0);
    check_eq("rd_idle_hold", a_rd_data, 32'hA3);

    // 3. Deletes and lowest free slot
    a_del_en = 1; a_del_idx = 5;
    step();
    check_eq("del5_count", 32'(a_used_count), 32'd7);
    check_eq("del5_free_idx", 32'(a_free_idx), 32'd5);
    check_eq("del5_full", 32'(a_full), 32'd0);
    a_del_idx = 2;
    step();
    check_eq("del2_count", 32'(a_used_count), 32'd6);
    check_eq("del2_free_idx", 32'(a_free_idx), 32'd2);
    step();
    idle_a();
    check_eq("del2_again_count", 32'(a_used_count), 32'd6);
    check_eq("del2_mask", 32'(a_valid_mask), 32'hDB);

    // 4. Simultaneous write/delete
    a_wr_en = 1; a_wr_idx = 4; a_wr_data = 32'h44; a_del_en = 1; a_del_idx = 4;
    step();
    idle_a();
    check_eq("wd_same_count", 32'(a_used_count), 32'd6);
    check_eq("wd_same_mask", 32'(a_valid_mask), 32'hDB);
    a_rd_en = 1; a_rd_idx = 4;
    step();
    idle_a();
    check_eq("wd_same_data", a_rd_data, 32'h44);
    a_wr_en = 1; a_wr_idx = 2; a_wr_data = 32'h12; a_del_en = 1; a_del_idx = 6;
    step();
    idle_a();
    check_eq("wd_diff_count", 32'(a_used_count), 32'd6);
    check_eq("wd_diff_mask", 32'(a_valid_mask), 32'h9F);
    check_eq("wd_diff_free_idx", 32'(a_free_idx), 32'd5);

    // 5. Read/write collision on idx 1
    a_wr_en = 1; a_wr_idx = 1; a_wr_data = 32'h11;
    step();
    check_eq("overwrite_count", 32'(a_used_count), 32'd6);
    a_wr_data = 32'h22; a_rd_en = 1; a_rd_idx = 1;
    step();
    idle_a();
`ifdef MEMORY_BANK_BYPASS_EN
    exp_collide = 32'h22;
`else
    exp_collide = 32'h11;
`endif
    check_eq("collide_data", a_rd_data, exp_collide);
    check_eq("collide_valid", 32'(a_rd_valid), 32'd1);
    a_rd_en = 1; a_rd_idx = 1;
    step();
    idle_a();
    check_eq("after_collide_data", a_rd_data, 32'h22);
    a_rd_en = 1; a_rd_idx = 5;
    step();
    idle_a();
    check_eq("rd_invalid_data", a_rd_data, 32'd0);
    check_eq("rd_invalid_valid", 32'(a_rd_valid), 32'd0);
    check_eq("rd_invalid_done", 32'(a_rd_done), 32'd1);

    // 6. Five-entry bank: out-of-range requests are ignored
    b_wr_en = 1; b_wr_idx = 1; b_wr_data = 8'h55;
    step();
    check_eq("b_wr1_count", 32'(b_used_count), 32'd1);
    b_wr_idx = 6; b_wr_data = 8'h66;
    step();
    b_wr_en = 0;
    check_eq("b_wr6_count", 32'(b_used_count), 32'd1);
    check_eq("b_wr6_mask", 32'(b_valid_mask), 32'h02);
    b_rd_en = 1; b_rd_idx = 1;
    step();
    check_eq("b_rd1_data", 32'(b_rd_data), 32'h55);
    b_rd_idx = 7;
    step();
    b_rd_en = 0;
    check_eq("b_rd7_done", 32'(b_rd_done), 32'd1);
    check_eq("b_rd7_valid", 32'(b_rd_valid), 32'd0);
    check_eq("b_rd7_data", 32'(b_rd_data), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i != 1) begin
        b_wr_en = 1; b_wr_idx = 3'(i); b_wr_data = 8'(i);
        step();
      end
    end
    b_wr_en = 0;
    check_eq("b_full", 32'(b_full), 32'd1);
    check_eq("b_full_count", 32'(b_used_count), 32'd5);
    check_eq("b_full_free_found", 32'(b_free_found), 32'd0);
    b_del_en = 1; b_del_idx = 7;
    step();
    b_del_en = 0;
    check_eq("b_del7_count", 32'(b_used_count), 32'd5);
    b_del_en = 1; b_del_idx = 3;
    step();
    b_del_en = 0;
    check_eq("b_del3_free_idx", 32'(b_free_idx), 32'd3);
    check_eq("b_del3_count", 32'(b_used_count), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
